// File: rtl/pt_axi4lite_initiator.sv
// Register-request to AXI4-Lite master bridge, one transaction in flight.
// Ports: i_clk/i_rst, req channel (address, wr_data, write, valid/ready),
//   rsp channel (rd_data, write, error, valid/ready), o_idle, and the
//   five AXI4-Lite master channels AW, W, B, AR, R.
module pt_axi4lite_initiator #(
  parameter int AXI_ADDR_W = 32,
  parameter int RF_ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter logic [2:0] PROT = 3'b000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_idle,
  input  logic [RF_ADDR_W-1:0] i_req_address,
  input  logic [DATA_W-1:0] i_req_wr_data,
  input  logic i_req_write,
  input  logic i_req_valid,
  output logic o_req_ready,
  output logic [DATA_W-1:0] o_rsp_rd_data,
  output logic o_rsp_write,
  output logic o_rsp_error,
  output logic o_rsp_valid,
  input  logic i_rsp_ready,
  output logic [AXI_ADDR_W-1:0] o_awaddr,
  output logic [2:0] o_awprot,
  output logic o_awvalid,
  input  logic i_awready,
  output logic [DATA_W-1:0] o_wdata,
  output logic [DATA_W/8-1:0] o_wstrb,
  output logic o_wvalid,
  input  logic i_wready,
  input  logic [1:0] i_bresp,
  input  logic i_bvalid,
  output logic o_bready,
  output logic [AXI_ADDR_W-1:0] o_araddr,
  output logic [2:0] o_arprot,
  output logic o_arvalid,
  input  logic i_arready,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [1:0] i_rresp,
  input  logic i_rvalid,
  output logic o_rready
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, RESPOND
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [RF_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_data_q;
  logic write_q;
  logic err_q;
  logic aw_done_q;
  logic w_done_q;
  logic aw_hs;
  logic w_hs;
  logic req_hs;

  // Only the error bit (bit 1) of xRESP matters: SLVERR and DECERR.
  logic unused_resp;
  assign unused_resp = i_bresp[0] ^ i_rresp[0];

  assign aw_hs = o_awvalid && i_awready;
  assign w_hs = o_wvalid && i_wready;
  assign req_hs = i_req_valid && o_req_ready;

  assign o_idle = (state_q == IDLE) && !i_req_valid;
  assign o_awaddr = AXI_ADDR_W'(addr_q);
  assign o_araddr = AXI_ADDR_W'(addr_q);
  assign o_wdata = wdata_q;
  assign o_wstrb = '1;
  assign o_awprot = PROT;
  assign o_arprot = PROT;
  assign o_rsp_rd_data = rd_data_q;
  assign o_rsp_write = write_q;
  assign o_rsp_error = err_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    o_req_ready = 1'b0;
    o_awvalid = 1'b0;
    o_wvalid = 1'b0;
    o_bready = 1'b0;
    o_arvalid = 1'b0;
    o_rready = 1'b0;
    o_rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          state_d = i_req_write ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        // AW and W complete independently, in either order.
        o_awvalid = !aw_done_q;
        o_wvalid = !w_done_q;
        if ((aw_done_q || i_awready) && (w_done_q || i_wready)) begin
          state_d = WR_RSP;
        end
      end
      WR_RSP: begin
        o_bready = 1'b1;
        if (i_bvalid) begin
          state_d = RESPOND;
        end
      end
      RD_REQ: begin
        o_arvalid = 1'b1;
        if (i_arready) begin
          state_d = RD_RSP;
        end
      end
      RD_RSP: begin
        o_rready = 1'b1;
        if (i_rvalid) begin
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rd_data_q <= '0;
      err_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
    end else begin
      if (req_hs) begin
        addr_q <= i_req_address;
        wdata_q <= i_req_wr_data;
        write_q <= i_req_write;
        aw_done_q <= 1'b0;
        w_done_q <= 1'b0;
      end
      if (aw_hs) begin
        aw_done_q <= 1'b1;
      end
      if (w_hs) begin
        w_done_q <= 1'b1;
      end
      if (o_bready && i_bvalid) begin
        err_q <= i_bresp[1];
        rd_data_q <= '0;
      end
      if (o_rready && i_rvalid) begin
        err_q <= i_rresp[1];
        rd_data_q <= i_rdata;
      end
    end
  end

endmodule

// File: tb/tb_pt_axi4lite_initiator.sv
// Bench for pt_axi4lite_initiator: AXI4-Lite memory slave with per-channel
// delays, expected-response queue model, and a per-cycle compare process.
module tb_pt_axi4lite_initiator;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic o_idle;
  logic [31:0] i_req_address = '0;
  logic [63:0] i_req_wr_data = '0;
  logic i_req_write = 1'b0;
  logic i_req_valid = 1'b0;
  logic o_req_ready;
  logic [63:0] o_rsp_rd_data;
  logic o_rsp_write;
  logic o_rsp_error;
  logic o_rsp_valid;
  logic i_rsp_ready = 1'b0;
  logic [31:0] o_awaddr;
  logic [2:0] o_awprot;
  logic o_awvalid;
  logic i_awready = 1'b0;
  logic [63:0] o_wdata;
  logic [7:0] o_wstrb;
  logic o_wvalid;
  logic i_wready = 1'b0;
  logic [1:0] i_bresp = '0;
  logic i_bvalid = 1'b0;
  logic o_bready;
  logic [31:0] o_araddr;
  logic [2:0] o_arprot;
  logic o_arvalid;
  logic i_arready = 1'b0;
  logic [63:0] i_rdata = '0;
  logic [1:0] i_rresp = '0;
  logic i_rvalid = 1'b0;
  logic o_rready;

  pt_axi4lite_initiator dut (
    .i_clk(i_clk), .i_rst(i_rst), .o_idle(o_idle),
    .i_req_address(i_req_address), .i_req_wr_data(i_req_wr_data),
    .i_req_write(i_req_write), .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready), .o_rsp_rd_data(o_rsp_rd_data),
    .o_rsp_write(o_rsp_write), .o_rsp_error(o_rsp_error),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_awaddr(o_awaddr), .o_awprot(o_awprot), .o_awvalid(o_awvalid),
    .i_awready(i_awready), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
    .o_wvalid(o_wvalid), .i_wready(i_wready), .i_bresp(i_bresp),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .o_araddr(o_araddr),
    .o_arprot(o_arprot), .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid),
    .o_rready(o_rready)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic wr;
    logic err;
    logic [63:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  logic [63:0] mmem [logic [31:0]];
  logic [63:0] smem [logic [31:0]];

  int aw_dly = 0, w_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0] resp_cfg = 2'b00;
  logic stray = 1'b0;

  logic aw_got, w_got, b_pend, r_pend;
  logic [31:0] aw_a;
  logic [63:0] w_d, r_dat;
  int aw_cnt, w_cnt, b_cnt, r_cnt;

  int cyc = 0;
  int acc_cyc, aw_cyc, w_cyc, b_cyc, ar_cyc, r_cyc, rspv_cyc;
  int aw_hi = 0, w_hi = 0, rr_hi = 0, b_hs_n = 0;
  logic last_wr, last_err;
  logic [63:0] last_rd = '0;

  logic aw_st, w_st, ar_st, rs_st, rv_last, rsp_hs_last;
  logic [31:0] aw_sa, ar_sa;
  logic [63:0] w_sd, rs_d;
  logic [2:0] rs_f;

  // Slave drive side: inputs to the DUT change only on the falling edge.
  always @(negedge i_clk) begin
    if (i_rst) begin
      i_awready = 1'b0;
      i_wready = 1'b0;
      i_arready = 1'b0;
      i_bvalid = 1'b0;
      i_rvalid = 1'b0;
    end else begin
      i_awready = o_awvalid && aw_cnt >= aw_dly;
      if (o_awvalid && !i_awready) aw_cnt++;
      i_wready = o_wvalid && w_cnt >= w_dly;
      if (o_wvalid && !i_wready) w_cnt++;
      i_arready = o_arvalid;
      i_bvalid = (b_pend && b_cnt >= b_dly) || stray;
      if (b_pend && !i_bvalid) b_cnt++;
      i_bresp = resp_cfg;
      i_rvalid = (r_pend && r_cnt >= r_dly) || stray;
      if (r_pend && !i_rvalid) r_cnt++;
      i_rdata = r_pend ? r_dat : 64'hBAD0_BAD0_BAD0_BAD0;
      i_rresp = resp_cfg;
    end
  end

  // Slave bookkeeping and the per-cycle compare process.
  always @(posedge i_clk) begin
    if (i_rst) begin
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0;
      aw_st = 0; w_st = 0; ar_st = 0; rs_st = 0;
      rv_last = 0; rsp_hs_last = 0;
    end else begin
      chk("wstrb", 64'(o_wstrb), 64'hFF);
      chk("prot", 64'({o_awprot, o_arprot}), 64'd0);
      if (aw_st) chk("aw_hold", 64'({o_awvalid, o_awaddr}), 64'({1'b1, aw_sa}));
      if (w_st) begin
        chk("w_hold_v", 64'(o_wvalid), 64'd1);
        chk("w_hold_d", o_wdata, w_sd);
      end
      if (ar_st) chk("ar_hold", 64'({o_arvalid, o_araddr}), 64'({1'b1, ar_sa}));
      if (rs_st) begin
        chk("rsp_hold_f", 64'({o_rsp_valid, o_rsp_write, o_rsp_error}),
            64'({1'b1, rs_f[1:0]}));
        chk("rsp_hold_d", o_rsp_rd_data, rs_d);
      end
      if (rsp_hs_last) chk("rdy_after_rsp", 64'(o_req_ready), 64'd1);
      if (o_awvalid) aw_hi++;
      if (o_wvalid) w_hi++;
      if (o_rready) rr_hi++;
      if (i_req_valid && o_req_ready) acc_cyc = cyc;
      if (o_awvalid && i_awready) begin
        aw_got = 1; aw_a = o_awaddr; aw_cyc = cyc; aw_cnt = 0;
      end
      if (o_wvalid && i_wready) begin
        w_got = 1; w_d = o_wdata; w_cyc = cyc; w_cnt = 0;
      end
      if (i_bvalid && o_bready) begin
        b_pend = 0; b_cyc = cyc; b_hs_n++;
      end
      if (aw_got && w_got) begin
        if (resp_cfg == 2'b00) smem[aw_a] = w_d;
        b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0;
      end
      if (i_rvalid && o_rready) begin
        r_pend = 0; r_cyc = cyc;
      end
      if (o_arvalid && i_arready) begin
        r_pend = 1; r_cnt = 0; ar_cyc = cyc;
        r_dat = smem.exists(o_araddr) ? smem[o_araddr] : 64'd0;
      end
      if (o_rsp_valid && !rv_last) rspv_cyc = cyc;
      if (o_rsp_valid && i_rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected got=%0h exp=none", o_rsp_rd_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_write", 64'(o_rsp_write), 64'(mon_e.wr));
          chk("rsp_error", 64'(o_rsp_error), 64'(mon_e.err));
          chk("rsp_data", o_rsp_rd_data, mon_e.data);
        end
        last_wr = o_rsp_write; last_err = o_rsp_error;
        last_rd = o_rsp_rd_data;
      end
      aw_st = o_awvalid && !i_awready; aw_sa = o_awaddr;
      w_st = o_wvalid && !i_wready; w_sd = o_wdata;
      ar_st = o_arvalid && !i_arready; ar_sa = o_araddr;
      rs_st = o_rsp_valid && !i_rsp_ready;
      rs_f = {o_rsp_valid, o_rsp_write, o_rsp_error}; rs_d = o_rsp_rd_data;
      rsp_hs_last = o_rsp_valid && i_rsp_ready;
      rv_last = o_rsp_valid;
      cyc++;
    end
  end

  // Called on a falling edge; returns on a falling edge after the response.
  task automatic do_req(input logic wr, input logic [31:0] a,
                        input logic [63:0] d, input logic [1:0] resp,
                        input int hold);
    rsp_t e;
    int n;
    resp_cfg = resp;
    e.wr = wr;
    e.err = resp[1];
    if (wr) begin
      e.data = 64'd0;
      if (resp == 2'b00) mmem[a] = d;
    end else begin
      e.data = mmem.exists(a) ? mmem[a] : 64'd0;
    end
    exp_q.push_back(e);
    i_req_valid = 1'b1; i_req_write = wr;
    i_req_address = a; i_req_wr_data = d;
    n = 0;
    while (!o_req_ready && n < 50) begin @(negedge i_clk); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL req_timeout got=busy exp=ready");
    end
    @(negedge i_clk);
    i_req_valid = 1'b0;
    n = 0;
    while (!o_rsp_valid && n < 100) begin @(negedge i_clk); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL rsp_timeout got=0 exp=1");
    end
    repeat (hold) @(negedge i_clk);
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
  endtask

  initial begin
    int n, prev;
    logic [31:0] a;
    logic [63:0] d;
    logic wr;
    repeat (3) @(negedge i_clk);
    i_req_valid = 1'b1;
    #1 chk("idle_follows_valid", 64'(o_idle), 64'd0);
    i_req_valid = 1'b0;
    #1 chk("idle_no_valid", 64'(o_idle), 64'd1);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_valids", 64'({o_awvalid, o_wvalid, o_arvalid, o_bready,
        o_rready, o_rsp_valid}), 64'd0);
    chk("rst_ready_idle", 64'({o_req_ready, o_idle}), 64'b11);
    chk("rst_addr", 64'({o_awaddr, o_araddr}), 64'd0);
    chk("rst_wdata", o_wdata, 64'd0);
    chk("rst_rsp", 64'({o_rsp_rd_data[0], o_rsp_write, o_rsp_error}), 64'd0);
    chk("rst_rdata", o_rsp_rd_data, 64'd0);

    do_req(1'b1, 32'h10, 64'hDEADBEEF_CAFEF00D, 2'b00, 0);
    chk("wr_aw_lat", 64'(aw_cyc - acc_cyc), 64'd1);
    chk("wr_w_lat", 64'(w_cyc - acc_cyc), 64'd1);
    chk("wr_b_lat", 64'(b_cyc - acc_cyc), 64'd2);
    chk("wr_rsp_lat", 64'(rspv_cyc - acc_cyc), 64'd3);
    chk("wr_rsp_lit", 64'({last_wr, last_err, last_rd[0]}), 64'b100);
    chk("wr_mem", smem[32'h10], 64'hDEADBEEF_CAFEF00D);

    do_req(1'b0, 32'h10, 64'd0, 2'b00, 0);
    chk("rd_ar_lat", 64'(ar_cyc - acc_cyc), 64'd1);
    chk("rd_r_lat", 64'(r_cyc - acc_cyc), 64'd2);
    chk("rd_rsp_lat", 64'(rspv_cyc - acc_cyc), 64'd3);
    chk("rd_back_lit", last_rd, 64'hDEADBEEF_CAFEF00D);

    smem[32'h20] = 64'h1234;
    mmem[32'h20] = 64'h1234;
    r_dly = 5; rr_hi = 0;
    do_req(1'b0, 32'h20, 64'd0, 2'b00, 0);
    r_dly = 0;
    chk("rd_wait_rready", 64'(rr_hi), 64'd6);
    chk("rd_wait_lit", 64'({last_wr, last_err}), 64'b00);
    chk("rd_wait_data", last_rd, 64'h1234);

    aw_dly = 3; aw_hi = 0; w_hi = 0; b_hs_n = 0;
    do_req(1'b1, 32'h48, 64'h0123_4567_89AB_CDEF, 2'b00, 0);
    aw_dly = 0;
    chk("aw_delay_cnt", 64'(aw_hi), 64'd4);
    chk("w_delay_cnt", 64'(w_hi), 64'd1);
    chk("b_once", 64'(b_hs_n), 64'd1);
    chk("wr_b_late_lat", 64'(b_cyc - acc_cyc), 64'd5);

    do_req(1'b0, 32'h48, 64'd0, 2'b10, 10);
    chk("slverr_lit", 64'({last_wr, last_err}), 64'b01);
    chk("slverr_data", last_rd, 64'h0123_4567_89AB_CDEF);
    do_req(1'b1, 32'h50, 64'h5555, 2'b11, 10);
    chk("decerr_lit", 64'({last_wr, last_err}), 64'b11);

    stray = 1'b1;
    repeat (4) begin
      @(negedge i_clk);
      chk("stray_idle", 64'({o_idle, o_rsp_valid}), 64'b10);
    end
    stray = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("stray_data", o_rsp_rd_data, last_rd);

    r_dly = 30;
    i_req_valid = 1'b1; i_req_write = 1'b0; i_req_address = 32'h30;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    n = 0;
    while (!o_rready && n < 20) begin @(negedge i_clk); n++; end
    chk("rst_reach_rd_rsp", 64'(o_rready), 64'd1);
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("midrst_valids", 64'({o_awvalid, o_wvalid, o_arvalid, o_bready,
        o_rready, o_rsp_valid}), 64'd0);
    chk("midrst_ready_idle", 64'({o_req_ready, o_idle}), 64'b11);
    i_rst = 1'b0;
    r_dly = 0;
    @(negedge i_clk);

    prev = -1;
    for (int k = 0; k < 24; k++) begin
      wr = 1'($urandom_range(0, 1));
      a = 32'h100 + 32'($urandom_range(0, 3)) * 8;
      d = {$urandom, $urandom};
      do_req(wr, a, d, 2'b00, 0);
      if (prev >= 0) chk("b2b_spacing", 64'(acc_cyc - prev), 64'd4);
      prev = acc_cyc;
    end

    repeat (2) @(negedge i_clk);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
